// File: rtl/instr_fetch_pkg.sv
// Shared processor constants for the instruction fetch stage.
// Opcode encoding: bit 7 set marks a two-byte instruction (opcode followed by a constant).
package instr_fetch_pkg;

    localparam int          OPC_TWO_BYTE_BIT = 7;
    localparam logic [7:0]  NOP_OPCODE       = 8'h00;

    function automatic logic isTwoByte(input logic [7:0] opcode);
        return opcode[OPC_TWO_BYTE_BIT];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory-side and pipeline-side signals of the fetch stage bundled into one interface.
// The master modport is the fetch unit; the slave modport is memory plus the downstream stage.
interface instr_fetch_if;

    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        accept;
    logic        cancel;
    logic [15:0] branch_addr;
    logic        halt;
    logic [7:0]  instr_out;
    logic [7:0]  const_out;
    logic        instr_valid;
    logic [15:0] instr_pc;

    modport master (
        output mem_addr, instr_out, const_out, instr_valid, instr_pc,
        input  mem_data, mem_ready, accept, cancel, branch_addr, halt
    );

    modport slave (
        input  mem_addr, instr_out, const_out, instr_valid, instr_pc,
        output mem_data, mem_ready, accept, cancel, branch_addr, halt
    );

endinterface

// File: rtl/instr_fetch_byte_fifo.sv
// Prefetch byte FIFO: one push and a 0/1/2-byte pop per cycle, exposing the two oldest bytes.
// Flush empties it in one cycle; the caller guarantees a push never overflows after the pop.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [7:0]                 i_push_data,
    input  logic [1:0]                 i_pop_cnt,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [7:0]                 o_head,
    output logic [7:0]                 o_second
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_plus_one;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_cnt);
            r_count  <= r_count + CNT_W'(i_push) - CNT_W'(i_pop_cnt);
        end
    end

    // Storage needs no reset: bytes are only visible through the count.
    always_ff @(posedge clk) begin
        if (i_push && !rst && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign w_rd_plus_one = r_rd_ptr + PTR_W'(1);
    assign o_count       = r_count;
    assign o_head        = r_mem[r_rd_ptr];
    assign o_second      = r_mem[w_rd_plus_one];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetches bytes into a prefetch FIFO and presents whole
// one- or two-byte instructions combinationally from the FIFO head.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]      r_fetch_pc;
    logic [15:0]      r_head_pc;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_after_pop;
    logic [7:0]       w_head;
    logic [7:0]       w_second;
    logic             w_head_two;
    logic             w_valid;
    logic [1:0]       w_pop_cnt;
    logic             w_push;

    // A two-byte opcode stays hidden until its constant byte is also buffered.
    assign w_head_two = isTwoByte(w_head);
    assign w_valid    = (w_count >= CNT_W'(2)) || ((w_count == CNT_W'(1)) && !w_head_two);

    always_comb begin
        w_pop_cnt = 2'd0;
        if (bus.accept && w_valid && !bus.cancel) begin
            w_pop_cnt = w_head_two ? 2'd2 : 2'd1;
        end
    end

    // Room is judged after this cycle's pop so a full FIFO can stream.
    assign w_count_after_pop = w_count - CNT_W'(w_pop_cnt);
    assign w_push = bus.mem_ready && !bus.halt && !bus.cancel
                    && (w_count_after_pop < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_VECTOR;
            r_head_pc  <= RESET_VECTOR;
        end else if (bus.cancel) begin
            r_fetch_pc <= bus.branch_addr;
            r_head_pc  <= bus.branch_addr;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 16'd1;
            end
            r_head_pc <= r_head_pc + 16'(w_pop_cnt);
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.cancel),
        .i_push      (w_push),
        .i_push_data (bus.mem_data),
        .i_pop_cnt   (w_pop_cnt),
        .o_count     (w_count),
        .o_head      (w_head),
        .o_second    (w_second)
    );

    assign bus.mem_addr    = r_fetch_pc;
    assign bus.instr_valid = w_valid;
    assign bus.instr_out   = w_valid ? w_head : NOP_OPCODE;
    assign bus.const_out   = (w_valid && w_head_two) ? w_second : NOP_OPCODE;
    assign bus.instr_pc    = r_head_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a 64K ROM model answers fetches combinationally and
// each scenario checks hand-computed outputs one cycle at a time.
module tb_instr_fetch;

    logic       clk;
    logic       rst;
    logic [7:0] rom [65536];
    int         checkCount;
    int         passCount;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_VECTOR (16'h0100),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_data = rom[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then let the edge pass and settle before checks.
    task automatic applyStimulus(input logic r, input logic c, input logic h,
                                 input logic a, input logic m, input logic [15:0] br);
        rst             = r;
        bus.cancel      = c;
        bus.halt        = h;
        bus.accept      = a;
        bus.mem_ready   = m;
        bus.branch_addr = br;
        @(posedge clk);
        #1;
    endtask

    task automatic checkInstr(input string tag, input logic v, input logic [7:0] op,
                              input logic [7:0] cst, input logic [15:0] pc);
        checkOutput({tag, ".valid"}, 16'(bus.instr_valid), 16'(v));
        checkOutput({tag, ".instr"}, 16'(bus.instr_out), 16'(op));
        checkOutput({tag, ".const"}, 16'(bus.const_out), 16'(cst));
        checkOutput({tag, ".pc"},    bus.instr_pc, pc);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
        rom[16'h0100] = 8'h01; rom[16'h0101] = 8'h02; rom[16'h0102] = 8'h03;
        rom[16'h0200] = 8'h85; rom[16'h0201] = 8'hAA; rom[16'h0202] = 8'h03;
        for (int i = 0; i < 8; i++) rom[16'h0300 + i] = 8'(8'h10 + i);
        rom[16'h0400] = 8'h20; rom[16'h0401] = 8'h21; rom[16'h0402] = 8'h22;
        rom[16'hFFFF] = 8'h80; rom[16'h0000] = 8'h55; rom[16'h0001] = 8'h07;
        rom[16'h0500] = 8'h30; rom[16'h0501] = 8'h31; rom[16'h0502] = 8'h32;
        rom[16'h0503] = 8'h33;
        rom[16'h0600] = 8'h9A; rom[16'h0601] = 8'hBB;

        // Reset, then stream three one-byte instructions.
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        checkOutput("rst.addr", bus.mem_addr, 16'h0100);
        checkInstr("rst", 0, 8'h00, 8'h00, 16'h0100);
        applyStimulus(0, 0, 0, 1, 1, 16'h0);
        checkInstr("seq0", 1, 8'h01, 8'h00, 16'h0100);
        checkOutput("seq0.addr", bus.mem_addr, 16'h0101);
        applyStimulus(0, 0, 0, 1, 1, 16'h0);
        checkInstr("seq1", 1, 8'h02, 8'h00, 16'h0101);
        applyStimulus(0, 0, 0, 1, 1, 16'h0);
        checkInstr("seq2", 1, 8'h03, 8'h00, 16'h0102);

        // Two-byte opcode split across wait states.
        applyStimulus(0, 1, 0, 1, 1, 16'h0200);
        checkInstr("br200", 0, 8'h00, 8'h00, 16'h0200);
        checkOutput("br200.addr", bus.mem_addr, 16'h0200);
        applyStimulus(0, 0, 0, 1, 1, 16'h0);
        checkInstr("half", 0, 8'h00, 8'h00, 16'h0200);
        applyStimulus(0, 0, 0, 1, 0, 16'h0);
        checkInstr("wait1", 0, 8'h00, 8'h00, 16'h0200);
        applyStimulus(0, 0, 0, 1, 0, 16'h0);
        checkInstr("wait2", 0, 8'h00, 8'h00, 16'h0200);
        checkOutput("wait2.addr", bus.mem_addr, 16'h0201);
        applyStimulus(0, 0, 0, 1, 1, 16'h0);
        checkInstr("two", 1, 8'h85, 8'hAA, 16'h0200);
        applyStimulus(0, 0, 0, 1, 1, 16'h0);
        checkInstr("after2", 1, 8'h03, 8'h00, 16'h0202);

        // Fill with ACCEPT low, then stream through a full FIFO.
        applyStimulus(0, 1, 0, 0, 1, 16'h0300);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 16'h0);
        checkOutput("full.addr", bus.mem_addr, 16'h0304);
        checkInstr("full", 1, 8'h10, 8'h00, 16'h0300);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 1, 1, 16'h0);
            checkInstr($sformatf("stream%0d", k), 1, 8'(8'h10 + k), 8'h00, 16'(16'h0300 + k));
            checkOutput($sformatf("stream%0d.addr", k), bus.mem_addr, 16'(16'h0304 + k));
        end

        // Cancel with three bytes buffered and ACCEPT high.
        applyStimulus(0, 1, 0, 0, 1, 16'h0400);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 16'h0);
        checkInstr("buf3", 1, 8'h20, 8'h00, 16'h0400);
        applyStimulus(0, 1, 0, 1, 1, 16'h2000);
        checkInstr("cancel", 0, 8'h00, 8'h00, 16'h2000);
        checkOutput("cancel.addr", bus.mem_addr, 16'h2000);

        // Fetch PC wraps through FFFF with a two-byte opcode straddling it.
        applyStimulus(0, 1, 0, 0, 1, 16'hFFFF);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        checkOutput("wrap.addr", bus.mem_addr, 16'h0000);
        checkOutput("wrap.valid", 16'(bus.instr_valid), 16'h0);
        applyStimulus(0, 0, 0, 0, 1, 16'h0);
        checkInstr("wrap", 1, 8'h80, 8'h55, 16'hFFFF);

        // HALT drains the buffer but issues no new fetches, then fetch resumes.
        applyStimulus(0, 1, 0, 0, 1, 16'h0500);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 16'h0);
        applyStimulus(0, 0, 1, 1, 1, 16'h0);
        checkInstr("halt1", 1, 8'h31, 8'h00, 16'h0501);
        applyStimulus(0, 0, 1, 1, 1, 16'h0);
        checkInstr("halt2", 1, 8'h32, 8'h00, 16'h0502);
        for (int k = 3; k <= 5; k++) begin
            applyStimulus(0, 0, 1, 1, 1, 16'h0);
            checkInstr($sformatf("halt%0d", k), 0, 8'h00, 8'h00, 16'h0503);
            checkOutput($sformatf("halt%0d.addr", k), bus.mem_addr, 16'h0503);
        end
        applyStimulus(0, 0, 0, 1, 1, 16'h0);
        checkInstr("resume", 1, 8'h33, 8'h00, 16'h0503);
        checkOutput("resume.addr", bus.mem_addr, 16'h0504);

        // Reset in the middle of a two-byte fetch wins over everything else.
        applyStimulus(0, 1, 0, 1, 1, 16'h0600);
        applyStimulus(0, 0, 0, 1, 1, 16'h0);
        checkOutput("mid.valid", 16'(bus.instr_valid), 16'h0);
        applyStimulus(1, 1, 0, 1, 1, 16'h3000);
        checkInstr("midrst", 0, 8'h00, 8'h00, 16'h0100);
        checkOutput("midrst.addr", bus.mem_addr, 16'h0100);
        applyStimulus(0, 0, 0, 1, 0, 16'h0);
        checkInstr("postrst", 0, 8'h00, 8'h00, 16'h0100);
        checkOutput("postrst.addr", bus.mem_addr, 16'h0100);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
